// File: rtl/vga_rd_pkg.sv
// Shared definitions for the VGA read-side scheduler: FSM state encoding,
// frame/buffer defaults and the burst length shared with the SDRAM write side.
package vga_rd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      CHECK,
      REQ,
      BUSY
   } rd_state_t;

   localparam int unsigned FRAME_WORDS_DEF = 307200;
   localparam int unsigned BURST_LEN_DEF   = 256;
   localparam int unsigned BUF0_BASE_DEF   = 32'h0000_0000;
   localparam int unsigned BUF1_BASE_DEF   = 32'h0010_0000;

   // Width of the per-frame word counters (remain / offset).
   localparam int unsigned CNT_W = 19;

   // Length of the next burst: a full burst, or whatever is left of the frame.
   function automatic logic [CNT_W-1:0] burst_len_of(input logic [CNT_W-1:0] remain,
                                                     input logic [CNT_W-1:0] burst);
      return (remain < burst) ? remain : burst;
   endfunction

endpackage

// File: rtl/vga_vs_edge.sv
// Two-flop synchronizer plus rising-edge detector for a VGA sync input.
// Usable for vs or hs; the edge is reported two cycles after the input rises.
module vga_vs_edge (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise
);

   logic q1;
   logic q2;

   // Synchronize the sync input through two stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         q1 <= 1'b0;
         q2 <= 1'b0;
      end else begin
         q1 <= sig;
         q2 <= q1;
      end
   end

   assign rise = q1 & ~q2;

endmodule

// File: rtl/vga_rd_sched.sv
// VGA read-side scheduler: refills the VGA read FIFO with burst reads from the
// ping-pong frame buffer, picking the most recently completed camera frame at
// every VGA frame start.
// Optional statistics outputs (frame_cnt, underrun_cnt) are enabled by
// defining VGA_RD_SCHED_STAT_EN.
module vga_rd_sched
   import vga_rd_pkg::*;
#(
   parameter int unsigned       ADDR_W      = 22,
   parameter int unsigned       LEN_W       = 9,
   parameter int unsigned       BURST_LEN   = BURST_LEN_DEF,
   parameter int unsigned       FRAME_WORDS = FRAME_WORDS_DEF,
   parameter int unsigned       USEDW_W     = 10,
   parameter int unsigned       REFILL_TH   = 512,
   parameter logic [ADDR_W-1:0] BUF0_BASE   = ADDR_W'(BUF0_BASE_DEF),
   parameter logic [ADDR_W-1:0] BUF1_BASE   = ADDR_W'(BUF1_BASE_DEF)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vga_vs,
   input  logic               wr_frame_done,
   input  logic               wr_buf,
   input  logic [USEDW_W-1:0] fifo_usedw,
   output logic               fifo_clr,
   output logic               rd_req,
   output logic [ADDR_W-1:0]  rd_addr,
   output logic [LEN_W-1:0]   rd_len,
   input  logic               rd_ack,
   input  logic               rd_done,
   output logic               active_buf,
   output logic               frame_busy
`ifdef VGA_RD_SCHED_STAT_EN
   ,
   output logic [15:0]        frame_cnt,
   output logic [15:0]        underrun_cnt
`endif
);

   localparam logic [CNT_W-1:0] FRAME_W = CNT_W'(FRAME_WORDS);
   localparam logic [CNT_W-1:0] BURST_W = CNT_W'(BURST_LEN);

   rd_state_t         state;
   logic              vs_rise;
   logic              ready_buf;
   logic              have_frame;
   logic              restart_pend;
   logic              restart_now;
   logic              burst_end;
   logic              fifo_low;
   logic [ADDR_W-1:0] base;
   logic [CNT_W-1:0]  remain;
   logic [CNT_W-1:0]  offset;
   logic [CNT_W-1:0]  next_len;
   logic [CNT_W-1:0]  done_len;

   vga_vs_edge u_vs_edge (
      .clk  (clk),
      .rst  (rst),
      .sig  (vga_vs),
      .rise (vs_rise)
   );

   assign fifo_low    = 32'(fifo_usedw) < REFILL_TH;
   assign next_len    = burst_len_of(remain, BURST_W);
   assign done_len    = CNT_W'(rd_len);
   assign restart_now = restart_pend | vs_rise;
   // An ack and done arriving together in REQ complete the burst immediately.
   assign burst_end   = ((state == REQ) && rd_ack && rd_done) ||
                        ((state == BUSY) && rd_done);

   // Remember the latest completed camera buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         have_frame <= 1'b0;
         ready_buf  <= 1'b0;
      end else if (wr_frame_done) begin
         have_frame <= 1'b1;
         ready_buf  <= wr_buf;
      end
   end

   // Frame fetch sequencer with registered outputs; fifo_clr is raised on
   // every transition into START so it is high exactly during START.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         fifo_clr     <= 1'b0;
         rd_req       <= 1'b0;
         rd_addr      <= BUF0_BASE;
         rd_len       <= '0;
         active_buf   <= 1'b0;
         frame_busy   <= 1'b0;
         base         <= BUF0_BASE;
         remain       <= '0;
         offset       <= '0;
         restart_pend <= 1'b0;
      end else begin
         fifo_clr <= 1'b0;
         case (state)
            IDLE: begin
               if (vs_rise && have_frame) begin
                  fifo_clr <= 1'b1;
                  state    <= START;
               end
            end
            START: begin
               active_buf   <= ready_buf;
               base         <= ready_buf ? BUF1_BASE : BUF0_BASE;
               remain       <= FRAME_W;
               offset       <= '0;
               frame_busy   <= 1'b1;
               restart_pend <= 1'b0;
               state        <= CHECK;
            end
            CHECK: begin
               if (vs_rise) begin
                  fifo_clr <= 1'b1;
                  state    <= START;
               end else if (remain == '0) begin
                  frame_busy <= 1'b0;
                  state      <= IDLE;
               end else if (fifo_low) begin
                  rd_addr <= base + ADDR_W'(offset);
                  rd_len  <= LEN_W'(next_len);
                  rd_req  <= 1'b1;
                  state   <= REQ;
               end
            end
            REQ, BUSY: begin
               if ((state == REQ) && rd_ack) begin
                  rd_req <= 1'b0;
               end
               if (burst_end) begin
                  offset       <= offset + done_len;
                  remain       <= remain - done_len;
                  restart_pend <= 1'b0;
                  if (restart_now) begin
                     fifo_clr <= 1'b1;
                     state    <= START;
                  end else begin
                     state <= CHECK;
                  end
               end else begin
                  restart_pend <= restart_now;
                  if ((state == REQ) && rd_ack) begin
                     state <= BUSY;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef VGA_RD_SCHED_STAT_EN
   // Count frame starts and cycles where the FIFO ran dry mid-frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt    <= '0;
         underrun_cnt <= '0;
      end else begin
         if (state == START) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
         if ((state == CHECK) && frame_busy && (fifo_usedw == '0) &&
             (underrun_cnt != '1)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_vga_rd_sched.sv
// Self-checking bench for vga_rd_sched: a full-size frame instance and a
// 1000-word frame instance share the VGA/camera/FIFO-level stimulus, each with
// its own randomized SDRAM responder. Expected burst sequences come from the
// frame layout arithmetic (base + k*BURST_LEN, length min(BURST_LEN, rest)).
module tb_vga_rd_sched;

   localparam int unsigned FW_A = 307200;
   localparam int unsigned FW_B = 1000;
   localparam int unsigned BL   = 256;
   localparam int unsigned TH   = 512;
   localparam logic [21:0] B0   = 22'h000000;
   localparam logic [21:0] B1   = 22'h100000;

   typedef struct packed {
      logic [21:0] addr;
      logic [8:0]  len;
   } req_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic vga_vs = 1'b1;
   logic wr_frame_done = 1'b0;
   logic wr_buf = 1'b0;
   logic [9:0] fifo_usedw = 10'd100;
   logic usedw_force = 1'b0;
   logic [9:0] usedw_at_edge;

   logic [1:0] fifo_clr, rd_req, rd_ack, rd_done, active_buf, frame_busy;
   logic [1:0][21:0] rd_addr;
   logic [1:0][8:0]  rd_len;
`ifdef VGA_RD_SCHED_STAT_EN
   logic [1:0][15:0] frame_cnt, underrun_cnt;
`endif

   logic [1:0] hold = 2'b00;
   logic [1:0] holding;
   logic [1:0] req_seen;
   int unsigned clr_cnt [2];
   req_t log_a [$];
   req_t log_b [$];

   int unsigned passed = 0;
   int unsigned total  = 0;
   int unsigned failed = 0;

   always #5 clk = ~clk;

   always @(posedge clk) usedw_at_edge <= fifo_usedw;

   vga_rd_sched #(.FRAME_WORDS(FW_A)) dut_a (
      .clk(clk), .rst(rst), .vga_vs(vga_vs), .wr_frame_done(wr_frame_done),
      .wr_buf(wr_buf), .fifo_usedw(fifo_usedw), .fifo_clr(fifo_clr[0]),
      .rd_req(rd_req[0]), .rd_addr(rd_addr[0]), .rd_len(rd_len[0]),
      .rd_ack(rd_ack[0]), .rd_done(rd_done[0]), .active_buf(active_buf[0]),
      .frame_busy(frame_busy[0])
`ifdef VGA_RD_SCHED_STAT_EN
      , .frame_cnt(frame_cnt[0]), .underrun_cnt(underrun_cnt[0])
`endif
   );

   vga_rd_sched #(.FRAME_WORDS(FW_B)) dut_b (
      .clk(clk), .rst(rst), .vga_vs(vga_vs), .wr_frame_done(wr_frame_done),
      .wr_buf(wr_buf), .fifo_usedw(fifo_usedw), .fifo_clr(fifo_clr[1]),
      .rd_req(rd_req[1]), .rd_addr(rd_addr[1]), .rd_len(rd_len[1]),
      .rd_ack(rd_ack[1]), .rd_done(rd_done[1]), .active_buf(active_buf[1]),
      .frame_busy(frame_busy[1])
`ifdef VGA_RD_SCHED_STAT_EN
      , .frame_cnt(frame_cnt[1]), .underrun_cnt(underrun_cnt[1])
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic vs_pulse();
      vga_vs = 1'b0;
      repeat (4) step();
      vga_vs = 1'b1;
   endtask

   task automatic frame_done(input logic b);
      wr_buf = b;
      wr_frame_done = 1'b1;
      step();
      wr_frame_done = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_clr%0d", tag, i), fifo_clr[i], 0);
         check($sformatf("%s_req%0d", tag, i), rd_req[i], 0);
         check($sformatf("%s_addr%0d", tag, i), rd_addr[i], B0);
         check($sformatf("%s_len%0d", tag, i), rd_len[i], 0);
         check($sformatf("%s_act%0d", tag, i), active_buf[i], 0);
         check($sformatf("%s_busy%0d", tag, i), frame_busy[i], 0);
`ifdef VGA_RD_SCHED_STAT_EN
         check($sformatf("%s_fcnt%0d", tag, i), frame_cnt[i], 0);
         check($sformatf("%s_ucnt%0d", tag, i), underrun_cnt[i], 0);
`endif
      end
   endtask

   // Background FIFO level: mostly below threshold, sometimes above, never 0.
   initial begin
      forever begin
         @(negedge clk);
         if (!usedw_force) begin
            if ($urandom_range(0, 3) == 0) fifo_usedw = 10'($urandom_range(512, 1023));
            else fifo_usedw = 10'($urandom_range(1, 511));
         end
      end
   end

   // SDRAM responders and output monitors for both instances.
   initial begin
      int unsigned st [2];
      int unsigned cnt [2];
      req_t cap [2];
      req_t r;
      rd_ack = '0;
      rd_done = '0;
      holding = '0;
      req_seen = '0;
      for (int i = 0; i < 2; i++) begin
         st[i] = 0;
         cnt[i] = 0;
         clr_cnt[i] = 0;
      end
      forever begin
         @(negedge clk);
         rd_ack = '0;
         rd_done = '0;
         holding = '0;
         for (int i = 0; i < 2; i++) begin
            if (fifo_clr[i]) clr_cnt[i]++;
            if (rst) begin
               st[i] = 0;
               req_seen[i] = 1'b0;
            end else begin
               if (rd_req[i] && !req_seen[i])
                  check($sformatf("req_below_th%0d", i), 32'(usedw_at_edge < 10'(TH)), 1);
               req_seen[i] = rd_req[i];
               if (st[i] == 0 && rd_req[i]) begin
                  cap[i] = '{addr: rd_addr[i], len: rd_len[i]};
                  cnt[i] = $urandom_range(0, 2);
                  st[i] = 1;
               end
               if (st[i] == 1) begin
                  if (cnt[i] == 0) begin
                     check($sformatf("req_stable%0d", i), {rd_req[i], rd_addr[i], rd_len[i]},
                           {1'b1, cap[i].addr, cap[i].len});
                     check($sformatf("busy_at_req%0d", i), frame_busy[i], 1);
                     r = '{addr: rd_addr[i], len: rd_len[i]};
                     if (i == 0) log_a.push_back(r);
                     else log_b.push_back(r);
                     rd_ack[i] = 1'b1;
                     if (!hold[i] && $urandom_range(0, 3) == 0) begin
                        rd_done[i] = 1'b1;
                        st[i] = 0;
                     end else begin
                        cnt[i] = $urandom_range(1, 4);
                        st[i] = 2;
                     end
                  end else begin
                     cnt[i]--;
                  end
               end else if (st[i] == 2) begin
                  if (hold[i]) begin
                     holding[i] = 1'b1;
                  end else begin
                     cnt[i]--;
                     if (cnt[i] == 0) begin
                        rd_done[i] = 1'b1;
                        st[i] = 0;
                     end
                  end
               end
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passed, total);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned n, nb, c, rest;
      req_t e;

      // Reset state.
      rst = 1'b1;
      repeat (4) step();
      check_reset("rst");
      rst = 1'b0;
      repeat (5) step();

      // A frame start before any camera frame is ignored.
      vs_pulse();
      repeat (20) step();
      check("noframe_req_a", log_a.size(), 0);
      check("noframe_req_b", log_b.size(), 0);
      check("noframe_clr_a", clr_cnt[0], 0);
      check("noframe_clr_b", clr_cnt[1], 0);

      // Buffer 1 completes, then a frame start: full frame fetched from buffer 1.
      frame_done(1'b1);
      vs_pulse();
      repeat (6) step();
      check("start_clr_a", clr_cnt[0], 1);
      check("start_clr_b", clr_cnt[1], 1);
      check("start_act_a", active_buf[0], 1);
      check("start_act_b", active_buf[1], 1);
      check("start_busy_a", frame_busy[0], 1);
      for (int k = 0; k < 30000 && !(log_a.size() == FW_A / BL && !frame_busy[0]); k++) step();
      check("frame_a_done", 32'(log_a.size() == FW_A / BL && !frame_busy[0]), 1);
      check("frame_a_count", log_a.size(), FW_A / BL);
      if (log_a.size() > 0) begin
         check("first_a", log_a[0], {B1, 9'd256});
         check("last_a", log_a[log_a.size() - 1], {22'(B1 + 306944), 9'd256});
      end
      for (int k = 0; k < log_a.size(); k++) begin
         e = '{addr: 22'(32'(B1) + k * BL), len: 9'(BL)};
         check($sformatf("burst_a_%0d", k), log_a[k], e);
      end
      check("frame_b_count", log_b.size(), 4);
      check("frame_b_idle", frame_busy[1], 0);
      for (int k = 0; k < log_b.size(); k++) begin
         rest = FW_B - k * BL;
         e = '{addr: 22'(32'(B1) + k * BL), len: 9'((rest < BL) ? rest : BL)};
         check($sformatf("burst_b_%0d", k), log_b[k], e);
      end

      // New frame from buffer 0, then a frame start while A is mid-burst.
      log_a.delete();
      log_b.delete();
      frame_done(1'b0);
      vs_pulse();
      for (int k = 0; k < 3000 && log_a.size() < 3; k++) step();
      check("s4_reqs", 32'(log_a.size() >= 3), 1);
      if (log_a.size() > 0) check("s4_first", log_a[0], {B0, 9'd256});
      hold[0] = 1'b1;
      for (int k = 0; k < 100 && !holding[0]; k++) step();
      check("s4_holding", holding[0], 1);
      n = log_a.size();
      c = clr_cnt[0];
      frame_done(1'b1);
      vs_pulse();
      repeat (8) step();
      check("s4_no_req", rd_req[0], 0);
      check("s4_no_new_burst", log_a.size(), n);
      check("s4_no_clr", clr_cnt[0], c);
      check("s4_busy", frame_busy[0], 1);
      check("s4_act_old", active_buf[0], 0);
      hold[0] = 1'b0;
      for (int k = 0; k < 100 && log_a.size() == n; k++) step();
      check("s4_restart_req", log_a.size(), n + 1);
      check("s4_restart_clr", clr_cnt[0], c + 1);
      if (log_a.size() > n) check("s4_restart_addr", log_a[n], {B1, 9'd256});
      check("s4_act_new", active_buf[0], 1);

      // FIFO held full across a frame start, then one empty cycle in CHECK.
      usedw_force = 1'b1;
      fifo_usedw = 10'd800;
      vs_pulse();
      repeat (30) step();
      n = log_a.size();
      nb = log_b.size();
      repeat (10) step();
      check("full_no_req_a", log_a.size(), n);
      check("full_no_req_b", log_b.size(), nb);
      check("full_busy_a", frame_busy[0], 1);
      check("full_busy_b", frame_busy[1], 1);
      log_a.delete();
      log_b.delete();
      fifo_usedw = 10'd0;
      step();
      fifo_usedw = 10'd800;
      repeat (3) step();
`ifdef VGA_RD_SCHED_STAT_EN
      check("frame_cnt_a", frame_cnt[0], 4);
      check("frame_cnt_b", frame_cnt[1], 4);
      check("underrun_a", underrun_cnt[0], 1);
      check("underrun_b", underrun_cnt[1], 1);
`endif
      usedw_force = 1'b0;
      for (int k = 0; k < 200 && (log_a.size() == 0 || log_b.size() == 0); k++) step();
      check("s5_req_a", 32'(log_a.size() > 0), 1);
      check("s5_req_b", 32'(log_b.size() > 0), 1);
      if (log_a.size() > 0) check("s5_addr_a", log_a[0], {B1, 9'd256});
      if (log_b.size() > 0) check("s5_addr_b", log_b[0], {B1, 9'd256});

      // Reset in the middle of a frame.
      for (int k = 0; k < 500 && log_a.size() < 3; k++) step();
      rst = 1'b1;
      repeat (3) step();
      check_reset("midrst");
      rst = 1'b0;
      step();
      check_reset("postrst");
      log_a.delete();
      log_b.delete();
      c = clr_cnt[0];
      nb = clr_cnt[1];
      repeat (5) step();
      vs_pulse();
      repeat (20) step();
      check("postrst_req_a", log_a.size(), 0);
      check("postrst_req_b", log_b.size(), 0);
      check("postrst_clr_a", clr_cnt[0], c);
      check("postrst_clr_b", clr_cnt[1], nb);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/vga_rd_sched.md
Name: vga_rd_sched

Overview:
- Read-side scheduler between the SDRAM controller and the VGA read FIFO. The VGA timing core drains that FIFO through vga_display_value/rd_q.
- Watches FIFO fill level and issues burst-read requests that refill one frame from a ping-pong frame buffer.
- Selects the most recently completed camera frame at each VGA frame start.
- Realigns the FIFO and read address on every frame boundary.

Parameters:
- ADDR_W, 22: SDRAM word-address width.
- LEN_W, 9: burst-length field width.
- BURST_LEN, 256: words per full burst; must be ≤ 2^LEN_W−1.
- FRAME_WORDS, 307200: 16-bit words per frame (640×480).
- USEDW_W, 10: FIFO used-words width.
- REFILL_TH, 512: request a burst when fifo_usedw < REFILL_TH.
- BUF0_BASE, 22'h000000: base address of buffer 0.
- BUF1_BASE, 22'h100000: base address of buffer 1.

Ports:
- clk, in, 1: system clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- vga_vs, in, 1: VGA vertical sync, active-low pulse; its rising edge marks the frame start.
- wr_frame_done, in, 1: 1-cycle pulse from the camera writer when a buffer is complete.
- wr_buf, in, 1: index of the buffer just completed; valid with wr_frame_done.
- fifo_usedw, in, USEDW_W: read FIFO level (write-side view).
- fifo_clr, out, 1: 1-cycle synchronous FIFO clear.
- rd_req, out, 1: burst-read request.
- rd_addr, out, ADDR_W: burst start address; stable while rd_req=1.
- rd_len, out, LEN_W: burst length; stable while rd_req=1.
- rd_ack, in, 1: 1-cycle grant from the SDRAM controller.
- rd_done, in, 1: 1-cycle pulse after the last word of the burst is written to the FIFO.
- active_buf, out, 1: buffer currently being displayed.
- frame_busy, out, 1: high while the current frame still has words left to fetch.

Behaviour:
- Reset values: all outputs 0; rd_addr = BUF0_BASE; rd_len = 0; ready_buf = 0; have_frame = 0; state IDLE.
- Frame-start detection: vga_vs is registered twice. vs_rise = (q1 & ~q2), so detection takes 2 cycles.
- Frame-ready tracking: wr_frame_done sets have_frame = 1 and ready_buf = wr_buf.
- State IDLE: wait for vs_rise with have_frame = 1. A vs_rise with have_frame = 0 is ignored.
- State START (1 cycle):
  - fifo_clr = 1.
  - active_buf ← ready_buf.
  - base ← BUF0_BASE or BUF1_BASE according to ready_buf.
  - remain ← FRAME_WORDS; frame_busy ← 1.
  - Next state: CHECK.
- State CHECK:
  - remain == 0: frame_busy ← 0, go to IDLE.
  - Else, fifo_usedw < REFILL_TH: load rd_addr = base + offset and rd_len = min(BURST_LEN, remain), go to REQ.
  - Otherwise stay in CHECK.
- State REQ: rd_req = 1 until rd_ack. On rd_ack, rd_req drops the same edge and the state moves to BUSY.
- State BUSY: on rd_done:
  - offset += rd_len; remain −= rd_len.
  - If restart_pend: clear it and go to START.
  - Else go to CHECK.
- Mid-frame restart:
  - vs_rise in CHECK: go to START next cycle.
  - vs_rise in REQ or BUSY: set restart_pend. The in-flight request is never withdrawn and a burst is never aborted.
- Simultaneous events:
  - wr_frame_done in the same cycle as START: the new wr_buf takes effect at the next frame, not this one.
  - rd_ack and rd_done in the same cycle: treat as ack then done. Go straight to CHECK, or to START if restart_pend.
- Last burst: rd_len = remain when remain < BURST_LEN. With 307200/256 there is no partial burst; the bench covers one with FRAME_WORDS = 1000.
- Arithmetic: remain and offset are 19 bits, enough for FRAME_WORDS. rd_addr = base + offset, truncated to ADDR_W (no wrap check).
- Reset mid-burst: all state returns to reset values. The SDRAM controller is reset by the same rst.

Optional Feature:
- Macro VGA_RD_SCHED_STAT_EN.
- With it defined, adds two outputs:
  - frame_cnt[15:0]: increments in START.
  - underrun_cnt[15:0]: increments when fifo_usedw == 0 and frame_busy == 1 for one cycle while the state is CHECK. Saturates at 16'hFFFF.
  - Both reset to 0.
- Without it, these ports and counters do not exist.

Decomposition:
- Shared package vga_rd_pkg holds:
  - the state encoding constants IDLE/START/CHECK/REQ/BUSY;
  - FRAME_WORDS and the BUF0_BASE/BUF1_BASE defaults;
  - the burst length constant shared with the SDRAM write scheduler.
- One natural sub-module, vga_vs_edge: the 2-flop synchronizer and rising-edge detector, reusable for hs.

Test Plan:
- Reset, then wr_frame_done with wr_buf=1, then vs_rise. Expect:
  - fifo_clr pulse.
  - active_buf=1.
  - First rd_req with rd_addr=22'h100000, rd_len=256.
- Model FIFO drain, 1200 total bursts (307200/256). Expect:
  - Each rd_addr step = 256.
  - Last rd_addr=22'h100000+306944.
  - frame_busy drops after the final rd_done.
  - No rd_req while fifo_usedw ≥ 512.
- vs_rise during BUSY. Expect:
  - rd_req held until rd_done.
  - Then fifo_clr.
  - Next rd_addr equals the base of ready_buf with offset 0.
- vs_rise before any wr_frame_done: no rd_req and no fifo_clr.
- FRAME_WORDS=1000, BURST_LEN=256. Expect rd_len sequence 256, 256, 256, 232, then IDLE.
- With VGA_RD_SCHED_STAT_EN: two frames plus one forced fifo_usedw=0 cycle mid-frame in CHECK. Expect frame_cnt=2 and underrun_cnt=1.
